// File: rtl/edge_point_feeder.sv
// Raster-scans a binary edge map held in BRAM and hands each set pixel to a
// Hough transformer, one (x,y) point at a time with a start/done handshake.
`timescale 1ns/1ps

module edge_point_feeder #(
   parameter int IMG_W = 640,
   parameter int IMG_H = 480
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        frame_start,
   output logic [18:0] edge_addr,
   input  logic        edge_data,
   output logic [9:0]  x,
   output logic [8:0]  y,
   output logic        start,
   input  logic        done,
   output logic        busy,
   output logic        frame_done,
   output logic [15:0] point_count
);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      FETCH     = 3'd1,
      LATCH     = 3'd2,
      ISSUE     = 3'd3,
      WAIT_DONE = 3'd4,
      ADVANCE   = 3'd5,
      FINISH    = 3'd6
   } state_t;

   localparam logic [9:0] X_LAST = 10'(IMG_W - 1);
   localparam logic [8:0] Y_LAST = 9'(IMG_H - 1);

   state_t state_r;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      if (v == 16'hFFFF) begin
         return v;
      end else begin
         return v + 16'd1;
      end
   endfunction

   // Scan FSM; edge_addr tracks y*IMG_W+x by stepping alongside x/y, so no multiplier.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r     <= IDLE;
         x           <= 10'd0;
         y           <= 9'd0;
         edge_addr   <= 19'd0;
         start       <= 1'b0;
         busy        <= 1'b0;
         frame_done  <= 1'b0;
         point_count <= 16'd0;
      end else begin
         start      <= 1'b0;
         frame_done <= 1'b0;
         case (state_r)
            IDLE: begin
               if (frame_start) begin
                  x           <= 10'd0;
                  y           <= 9'd0;
                  edge_addr   <= 19'd0;
                  point_count <= 16'd0;
                  busy        <= 1'b1;
                  state_r     <= FETCH;
               end else begin
                  state_r <= IDLE;
               end
            end
            FETCH: begin
               state_r <= LATCH;
            end
            LATCH: begin
               // start is registered here so it is high exactly while in ISSUE
               if (edge_data) begin
                  start       <= 1'b1;
                  point_count <= sat_inc16(point_count);
                  state_r     <= ISSUE;
               end else begin
                  state_r <= ADVANCE;
               end
            end
            ISSUE: begin
               state_r <= WAIT_DONE;
            end
            WAIT_DONE: begin
               if (done) begin
                  state_r <= ADVANCE;
               end else begin
                  state_r <= WAIT_DONE;
               end
            end
            ADVANCE: begin
               if (x == X_LAST) begin
                  if (y == Y_LAST) begin
                     frame_done <= 1'b1;
                     state_r    <= FINISH;
                  end else begin
                     x         <= 10'd0;
                     y         <= y + 9'd1;
                     edge_addr <= edge_addr + 19'd1;
                     state_r   <= FETCH;
                  end
               end else begin
                  x         <= x + 10'd1;
                  edge_addr <= edge_addr + 19'd1;
                  state_r   <= FETCH;
               end
            end
            FINISH: begin
               busy    <= 1'b0;
               state_r <= IDLE;
            end
            default: begin
               busy    <= 1'b0;
               state_r <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_edge_point_feeder.sv
// Scoreboard bench: a 4x2 instance for the directed scenarios and a 112x101
// instance for a single deep edge point; expected points are queued up front.
`timescale 1ns/1ps

module tb_edge_point_feeder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset;

   logic        s_frame_start, s_edge_data, s_start, s_done, s_busy, s_frame_done;
   logic [18:0] s_edge_addr;
   logic [9:0]  s_x;
   logic [8:0]  s_y;
   logic [15:0] s_point_count;
   logic [7:0]  s_map;

   logic        b_frame_start, b_edge_data, b_start, b_done, b_busy, b_frame_done;
   logic [18:0] b_edge_addr;
   logic [9:0]  b_x;
   logic [8:0]  b_y;
   logic [15:0] b_point_count;

   edge_point_feeder #(.IMG_W(4), .IMG_H(2)) dut_small (
      .clk(clk), .reset(reset), .frame_start(s_frame_start), .edge_addr(s_edge_addr),
      .edge_data(s_edge_data), .x(s_x), .y(s_y), .start(s_start), .done(s_done),
      .busy(s_busy), .frame_done(s_frame_done), .point_count(s_point_count));

   edge_point_feeder #(.IMG_W(112), .IMG_H(101)) dut_big (
      .clk(clk), .reset(reset), .frame_start(b_frame_start), .edge_addr(b_edge_addr),
      .edge_data(b_edge_data), .x(b_x), .y(b_y), .start(b_start), .done(b_done),
      .busy(b_busy), .frame_done(b_frame_done), .point_count(b_point_count));

   typedef struct packed {
      logic [9:0]  px;
      logic [8:0]  py;
      logic [18:0] addr;
      logic [15:0] cnt;
   } pt_t;

   pt_t s_exp[$];
   pt_t b_exp[$];
   pt_t s_e, b_e;
   int  errors = 0;
   int  checks = 0;
   int  s_fd_count = 0, b_fd_count = 0, s_start_count = 0, b_start_count = 0;
   int  done_delay = 2;
   bit  done_early = 1'b0;
   logic s_prev_start = 1'b0, b_prev_start = 1'b0;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Edge-map BRAMs with one cycle of read latency
   always @(posedge clk) begin
      s_edge_data <= s_map[s_edge_addr[2:0]];
      b_edge_data <= (b_edge_addr == 19'd11300);
   end

   // Monitor: pop expected point on each start pulse
   always @(negedge clk) begin
      if (s_start) begin
         s_start_count++;
         check("s_start_back_to_back", int'(s_prev_start), 0);
         check("s_start_with_frame_done", int'(s_frame_done), 0);
         if (s_exp.size() == 0) begin
            check("s_unexpected_start_x", int'(s_x), -1);
         end else begin
            s_e = s_exp.pop_front();
            check("s_pt_x", int'(s_x), int'(s_e.px));
            check("s_pt_y", int'(s_y), int'(s_e.py));
            check("s_pt_addr", int'(s_edge_addr), int'(s_e.addr));
            check("s_pt_count", int'(s_point_count), int'(s_e.cnt));
         end
      end
      if (s_frame_done) s_fd_count++;
      s_prev_start = s_start;
      if (b_start) begin
         b_start_count++;
         check("b_start_back_to_back", int'(b_prev_start), 0);
         if (b_exp.size() == 0) begin
            check("b_unexpected_start_x", int'(b_x), -1);
         end else begin
            b_e = b_exp.pop_front();
            check("b_pt_x", int'(b_x), int'(b_e.px));
            check("b_pt_y", int'(b_y), int'(b_e.py));
            check("b_pt_addr", int'(b_edge_addr), int'(b_e.addr));
            check("b_pt_count", int'(b_point_count), int'(b_e.cnt));
         end
      end
      if (b_frame_done) b_fd_count++;
      b_prev_start = b_start;
   end

   // Hough stand-in for the small instance
   initial forever begin
      @(negedge clk);
      if (s_start) begin
         if (done_early) begin
            s_done = 1'b1;
            @(negedge clk);
            s_done = 1'b0;
            repeat (10) @(negedge clk);
            s_done = 1'b1;
            @(negedge clk);
            s_done = 1'b0;
         end else if (done_delay > 0) begin
            repeat (done_delay) @(negedge clk);
            s_done = 1'b1;
            @(negedge clk);
            s_done = 1'b0;
         end
      end
   end

   // Hough stand-in for the big instance: done 5 cycles after start
   initial forever begin
      @(negedge clk);
      if (b_start) begin
         repeat (5) @(negedge clk);
         b_done = 1'b1;
         @(negedge clk);
         b_done = 1'b0;
      end
   end

   task automatic pulse_small();
      s_frame_start = 1'b1;
      @(negedge clk);
      s_frame_start = 1'b0;
   endtask

   task automatic wait_small_done(input int limit, output int n);
      n = 0;
      while (n < limit) begin
         @(negedge clk);
         n++;
         if (s_frame_done) break;
      end
   endtask

   task automatic wait_small_start(input int limit);
      int n = 0;
      while (n < limit && !s_start) begin
         @(negedge clk);
         n++;
      end
      check("s_start_seen", int'(s_start), 1);
   endtask

   initial begin
      int n;
      int fd_base;
      reset = 1'b1;
      s_frame_start = 1'b0; s_done = 1'b0; s_map = 8'h00;
      b_frame_start = 1'b0; b_done = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_x", int'(s_x), 0);
      check("rst_y", int'(s_y), 0);
      check("rst_addr", int'(s_edge_addr), 0);
      check("rst_start", int'(s_start), 0);
      check("rst_busy", int'(s_busy), 0);
      check("rst_frame_done", int'(s_frame_done), 0);
      check("rst_count", int'(s_point_count), 0);
      check("rst_big_busy", int'(b_busy), 0);
      reset = 1'b0;
      @(negedge clk);

      // Empty map: 8 pixels x 3 cycles
      s_map = 8'h00;
      fd_base = s_fd_count;
      pulse_small();
      check("empty_busy", int'(s_busy), 1);
      wait_small_done(60, n);
      check("empty_latency", n, 24);
      check("empty_frame_done", int'(s_frame_done), 1);
      check("empty_count", int'(s_point_count), 0);
      @(negedge clk);
      check("empty_busy_after", int'(s_busy), 0);
      check("empty_hold_x", int'(s_x), 3);
      check("empty_hold_y", int'(s_y), 1);
      check("empty_hold_addr", int'(s_edge_addr), 7);
      repeat (3) @(negedge clk);
      check("empty_fd_pulses", s_fd_count - fd_base, 1);
      check("empty_no_start", s_start_count, 0);

      // Row wrap: edges at (3,0) and (0,1)
      s_map = 8'b0001_1000;
      done_delay = 2;
      s_exp.push_back('{px: 10'd3, py: 9'd0, addr: 19'd3, cnt: 16'd1});
      s_exp.push_back('{px: 10'd0, py: 9'd1, addr: 19'd4, cnt: 16'd2});
      pulse_small();
      wait_small_done(100, n);
      check("wrap_latency", n, 30);
      check("wrap_count", int'(s_point_count), 2);
      repeat (2) @(negedge clk);

      // done high during ISSUE, then low for 10 cycles
      s_map = 8'b0010_0000;
      done_early = 1'b1;
      s_exp.push_back('{px: 10'd1, py: 9'd1, addr: 19'd5, cnt: 16'd1});
      pulse_small();
      wait_small_start(50);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("hold_x", int'(s_x), 1);
         check("hold_y", int'(s_y), 1);
         check("hold_addr", int'(s_edge_addr), 5);
      end
      @(negedge clk);
      check("hold_x_done_cycle", int'(s_x), 1);
      repeat (2) @(negedge clk);
      check("adv_x", int'(s_x), 2);
      check("adv_addr", int'(s_edge_addr), 6);
      done_early = 1'b0;
      wait_small_done(60, n);
      check("hold_frame_done", int'(s_frame_done), 1);
      check("hold_count", int'(s_point_count), 1);
      repeat (2) @(negedge clk);

      // Reset in WAIT_DONE, together with frame_start
      s_map = 8'b0000_0100;
      done_delay = 0;
      s_exp.push_back('{px: 10'd2, py: 9'd0, addr: 19'd2, cnt: 16'd1});
      fd_base = s_fd_count;
      pulse_small();
      wait_small_start(50);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      s_frame_start = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      s_frame_start = 1'b0;
      check("abort_x", int'(s_x), 0);
      check("abort_y", int'(s_y), 0);
      check("abort_addr", int'(s_edge_addr), 0);
      check("abort_start", int'(s_start), 0);
      check("abort_busy", int'(s_busy), 0);
      check("abort_frame_done", int'(s_frame_done), 0);
      check("abort_count", int'(s_point_count), 0);
      repeat (5) @(negedge clk);
      check("abort_busy_later", int'(s_busy), 0);
      check("abort_no_fd", s_fd_count - fd_base, 0);
      s_map = 8'b0000_0001;
      done_delay = 1;
      s_exp.push_back('{px: 10'd0, py: 9'd0, addr: 19'd0, cnt: 16'd1});
      pulse_small();
      wait_small_done(60, n);
      check("rescan_latency", n, 26);
      check("rescan_count", int'(s_point_count), 1);
      repeat (2) @(negedge clk);

      // frame_start mid-scan and in the FINISH cycle are ignored
      s_map = 8'h00;
      fd_base = s_fd_count;
      pulse_small();
      n = 0;
      while (n < 60) begin
         @(negedge clk);
         n++;
         if (n == 10) s_frame_start = 1'b1;
         if (n == 11) s_frame_start = 1'b0;
         if (s_frame_done) break;
      end
      check("ignore_latency", n, 24);
      s_frame_start = 1'b1;
      @(negedge clk);
      s_frame_start = 1'b0;
      repeat (40) @(negedge clk);
      check("ignore_fd_pulses", s_fd_count - fd_base, 1);
      check("ignore_busy", int'(s_busy), 0);
      check("ignore_hold_x", int'(s_x), 3);

      // Deep single edge at (100,100) on a 112x101 map
      b_exp.push_back('{px: 10'd100, py: 9'd100, addr: 19'd11300, cnt: 16'd1});
      b_frame_start = 1'b1;
      @(negedge clk);
      b_frame_start = 1'b0;
      n = 0;
      while (n < 40000) begin
         @(negedge clk);
         n++;
         if (b_frame_done) break;
      end
      check("big_latency", n, 33942);
      check("big_count", int'(b_point_count), 1);
      check("big_hold_x", int'(b_x), 111);
      check("big_hold_y", int'(b_y), 100);
      check("big_hold_addr", int'(b_edge_addr), 11311);
      repeat (3) @(negedge clk);

      check("s_queue_empty", s_exp.size(), 0);
      check("b_queue_empty", b_exp.size(), 0);
      check("s_start_total", s_start_count, 5);
      check("b_start_total", b_start_count, 1);
      check("b_fd_total", b_fd_count, 1);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/edge_point_feeder.md
EDGE_POINT_FEEDER -- requirements
Module: edge_point_feeder

Interface
REQ-001 SHALL have parameter IMG_W, default 640, image width in pixels.
REQ-002 SHALL have parameter IMG_H, default 480, image height in pixels.
REQ-003 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port frame_start  input  1  one-cycle pulse that begins a scan of the edge map.
REQ-006 SHALL have port edge_addr  output  19  edge-map BRAM read address, row-major: y*IMG_W+x.
REQ-007 SHALL have port edge_data  input  1  edge bit, valid one cycle after edge_addr is driven.
REQ-008 SHALL have port x  output  10  column of the current edge point, to the Hough transformer.
REQ-009 SHALL have port y  output  9  row of the current edge point, to the Hough transformer.
REQ-010 SHALL have port start  output  1  one-cycle pulse telling the Hough transformer to vote for (x,y).
REQ-011 SHALL have port done  input  1  Hough transformer has finished the current point.
REQ-012 SHALL have port busy  output  1  high from scan acceptance until frame_done.
REQ-013 SHALL have port frame_done  output  1  one-cycle pulse when the last pixel has been processed.
REQ-014 SHALL have port point_count  output  16  number of edge points issued in the current or last frame.

Function
REQ-015 SHALL implement the states IDLE, FETCH, LATCH, ISSUE, WAIT_DONE, ADVANCE and FINISH.
REQ-016 IDLE: on frame_start=1, SHALL clear x, y, edge_addr and point_count to 0, set busy=1 and go to FETCH.
REQ-017 FETCH: SHALL drive edge_addr for the current (x,y), then go to LATCH.
REQ-018 LATCH: SHALL sample edge_data; if 1, go to ISSUE; if 0, go to ADVANCE.
REQ-019 ISSUE: SHALL assert start for exactly one cycle, increment point_count (saturating at 65535), then go to WAIT_DONE.
REQ-020 WAIT_DONE: SHALL stay until done=1, then go to ADVANCE; done is ignored in every other state, including the ISSUE cycle.
REQ-021 x and y SHALL be held constant from ISSUE through the cycle in which done is sampled.
REQ-022 ADVANCE: if x=IMG_W-1 and y=IMG_H-1, SHALL go to FINISH.
REQ-023 ADVANCE, otherwise, at the end of a row (x=IMG_W-1): SHALL set x=0, increment y and increment edge_addr by 1, then go to FETCH.
REQ-024 ADVANCE, all other pixels: SHALL increment x and increment edge_addr by 1, then go to FETCH.
REQ-025 edge_addr SHALL be kept as an incrementing counter (no multiplier) and SHALL equal y*IMG_W+x in every state.
REQ-026 FINISH: SHALL pulse frame_done for one cycle, set busy=0 and go to IDLE.
REQ-027 x, y, edge_addr and point_count SHALL hold their final values in IDLE until the next accepted frame_start.
REQ-028 frame_start SHALL be ignored in every state except IDLE, including the FINISH cycle.
REQ-029 Latency: a zero pixel SHALL take 3 cycles (FETCH, LATCH, ADVANCE); an edge pixel SHALL take 4 cycles plus the cycles spent in WAIT_DONE.
REQ-030 start SHALL never be asserted in two consecutive cycles.
REQ-031 frame_done and start SHALL never be asserted in the same cycle.

Reset
REQ-032 reset=1 SHALL force IDLE and clear x, y, edge_addr, start, busy, frame_done and point_count to 0 on the next edge, in any state.
REQ-033 reset SHALL take priority over frame_start and done.
REQ-034 reset asserted mid-scan (including in WAIT_DONE) SHALL abort the scan with no frame_done pulse.

Verification
REQ-035 Empty map (all 0), IMG_W=4, IMG_H=2, frame_start -> no start pulse; frame_done exactly 24 cycles after the frame_start cycle; point_count=0.
REQ-036 Single edge at (100,100), default size, done returned 5 cycles after start -> exactly one start pulse with x=100, y=100, edge_addr=64100; point_count=1.
REQ-037 Edges at (3,0) and (0,1) with IMG_W=4 -> start pulses in that order with edge_addr 3 then 4; checks the row wrap.
REQ-038 done held high during ISSUE and then low for 10 cycles -> x and y stay stable and no ADVANCE occurs until done is sampled in WAIT_DONE.
REQ-039 reset asserted in WAIT_DONE -> next cycle: IDLE, all outputs 0, no frame_done; a later frame_start rescans from (0,0).
REQ-040 frame_start pulsed mid-scan and again in the FINISH cycle -> both ignored; only one frame_done pulse.
